// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral: shared prescaler and 256-step counter, per-channel
// enable / PWM-mode select, duty latched once per period, registered outputs.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PRESCALE_MAX = 16'(CLK_DIV - 1);

  logic [15:0] prescale_reg;
  logic [7:0]  step_reg;
  logic [7:0]  duty_shadow_reg;
  logic        started_reg;
  logic [15:0] out_reg;
  logic        period_start_reg;

  logic        step_tick;
  logic        period_wrap;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_next;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign step_tick   = started_reg && (prescale_reg == PRESCALE_MAX);
  assign period_wrap = step_tick && (step_reg == 8'hFF);

  // 0xFF is forced to constant high so full duty has no low step at 255.
  assign pwm_level = (duty_shadow_reg == 8'hFF) || (step_reg < duty_shadow_reg);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_chan
      assign out_next[gi] = en_out[gi] & (en_pwm[gi] ? pwm_level : 1'b1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_reg     <= '0;
      step_reg         <= '0;
      duty_shadow_reg  <= '0;
      started_reg      <= 1'b0;
      out_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      // The first edge out of reset only latches the duty; counting begins on
      // the next edge so the opening period is full length with the new duty.
      if (!started_reg) begin
        started_reg     <= 1'b1;
        duty_shadow_reg <= pwm_duty_cycle;
      end else begin
        prescale_reg <= step_tick ? 16'd0 : prescale_reg + 16'd1;
        if (step_tick) begin
          step_reg <= step_reg + 8'd1;
        end
        if (period_wrap) begin
          duty_shadow_reg <= pwm_duty_cycle;
        end
      end
      out_reg          <= out_next;
      period_start_reg <= started_reg && (prescale_reg == 16'd0) && (step_reg == 8'd0);
    end
  end

  assign out          = out_reg;
  assign period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral (CLK_DIV = 13): expectations are queued as
// stimulus is applied and popped when the corresponding output is sampled.
module tb_pwm_peripheral;

  localparam int DIV    = 13;
  localparam int PERIOD = 256 * DIV;
  localparam int LIMIT  = PERIOD + 700;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic [15:0] out;
  logic        period_start;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  pwm_peripheral #(.CLK_DIV(DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed=%0h expected=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
      $display("check %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  function automatic logic [15:0] model_out(input int cyc, input logic [7:0] d);
    logic lvl;
    lvl = (d == 8'hFF) || ((cyc / DIV) < int'(d));
    return en_out & ~(en_pwm & {16{~lvl}});
  endfunction

  task automatic wait_ps();
    int n;
    n = 0;
    while (period_start !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    push("wait_period_start", 32'd1);
    pop_check({31'd0, period_start});
  endtask

  // Called at a negedge where period_start is high; returns at the next one.
  task automatic measure(input int ch, input int change_at, input logic [7:0] new_duty,
                         input bit vec_chk, input logic [7:0] mdl_duty,
                         output int len, output int high, output int bad);
    len  = 0;
    high = 0;
    bad  = 0;
    do begin
      if (len == change_at) duty = new_duty;
      if (out[ch] === 1'b1) high++;
      if (vec_chk && out !== model_out(len, mdl_duty)) bad++;
      len++;
      @(negedge clk);
    end while (period_start !== 1'b1 && len < LIMIT);
  endtask

  task automatic period_check(input string tag, input int ch, input int change_at,
                              input logic [7:0] new_duty, input bit vec_chk,
                              input logic [7:0] mdl_duty, input int exp_high);
    int len, high, bad;
    push({tag, "_len"}, PERIOD);
    push({tag, "_high"}, exp_high);
    if (vec_chk) push({tag, "_vec_bad"}, 0);
    measure(ch, change_at, new_duty, vec_chk, mdl_duty, len, high, bad);
    pop_check(len);
    pop_check(high);
    if (vec_chk) pop_check(bad);
  endtask

  initial begin
    int len, high, bad;

    rst    = 1'b1;
    en_out = 16'hFFFF;
    en_pwm = 16'hFFFF;
    duty   = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      push("reset_out", 0);
      pop_check(out);
      push("reset_period_start", 0);
      pop_check({31'd0, period_start});
    end

    en_out = 16'h0000;
    en_pwm = 16'h0000;
    duty   = 8'h00;
    rst    = 1'b0;
    repeat (3) @(negedge clk);
    push("disabled_out", 0);
    pop_check(out);

    // Static mode: one clk of latency, then constant high.
    en_out = 16'hFFFF;
    #1;
    push("static_before_edge", 0);
    pop_check(out);
    @(negedge clk);
    push("static_after_edge", 16'hFFFF);
    pop_check(out);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out !== 16'hFFFF) bad++;
    end
    push("static_constant_bad", 0);
    pop_check(bad);

    // Duty 0x80 on channel 0.
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'h80;
    wait_ps();
    measure(0, -1, 8'h00, 1'b0, 8'h00, len, high, bad);
    period_check("duty80_a", 0, -1, 8'h00, 1'b1, 8'h80, 1664);
    period_check("duty80_b", 0, -1, 8'h00, 1'b1, 8'h80, 1664);

    // Boundaries; the first period after each change still runs the old duty.
    duty = 8'h00;
    period_check("duty80_held", 0, -1, 8'h00, 1'b0, 8'h00, 1664);
    for (int p = 0; p < 3; p++) period_check("duty00", 0, -1, 8'h00, 1'b1, 8'h00, 0);
    duty = 8'hFF;
    period_check("duty00_held", 0, -1, 8'h00, 1'b0, 8'h00, 0);
    for (int p = 0; p < 3; p++) period_check("dutyFF", 0, -1, 8'h00, 1'b1, 8'hFF, PERIOD);

    // Shadow: change 0x40 -> 0xC0 halfway through a 0x40 period.
    duty = 8'h40;
    period_check("dutyFF_held", 0, -1, 8'h00, 1'b0, 8'h00, PERIOD);
    period_check("shadow_cur", 0, PERIOD / 2, 8'hC0, 1'b0, 8'h00, 832);
    period_check("shadow_next", 0, -1, 8'h00, 1'b0, 8'h00, 2496);

    // Mixed channels.
    en_out = 16'h00F0;
    en_pwm = 16'h0030;
    duty   = 8'h40;
    measure(4, -1, 8'h00, 1'b0, 8'h00, len, high, bad);
    push("mixed_step0", 16'h00F0);
    pop_check(out);
    period_check("mixed", 4, -1, 8'h00, 1'b1, 8'h40, 832);

    // Reset mid-period, then a clean first period with the current duty.
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      push("midreset_out", 0);
      pop_check(out);
      push("midreset_period_start", 0);
      pop_check({31'd0, period_start});
    end
    rst = 1'b0;
    @(negedge clk);
    push("release_ps_early", 0);
    pop_check({31'd0, period_start});
    push("release_out_early", 16'h00C0);
    pop_check(out);
    @(negedge clk);
    push("release_ps", 1);
    pop_check({31'd0, period_start});
    push("release_out_step0", 16'h00F0);
    pop_check(out);
    period_check("after_reset", 4, -1, 8'h00, 1'b1, 8'h40, 832);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
